// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Instruction prefetcher for the 6502 core. Bytes are streamed from program
//   memory into a small circular byte queue independently of the decoder. The
//   queue head is length-decoded and a complete instruction (opcode plus up to
//   two operand bytes) is offered over a valid/ready handshake.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   mem_req/mem_addr/mem_gnt  read request channel (request held until granted)
//   mem_rvalid/mem_rdata      in-order read response channel
//   redirect_valid/_pc        flush the queue and restart fetch at redirect_pc
//   instr_valid/instr_ready   decoder handshake
//   instr_opcode/op1/op2      instruction bytes (unused operands read as 0)
//   instr_len                 instruction length 1..3 (0 when not valid)
//   instr_pc/pc_next          opcode address and address of the following one
module fetch_prefetch_queue #(
  parameter int                    ADDR_WIDTH      = 16,
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    QUEUE_DEPTH     = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 'h8000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_op1,
  output logic [DATA_WIDTH-1:0] instr_op2,
  output logic [1:0]            instr_len,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pc_next
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;

  // 6502 length decode, opcode = aaabbbcc. The single-byte cases are tested
  // first so they win over the bbb-based three-byte patterns.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    bbb = op[4:2];
    cc  = op[1:0];
    if (op == 8'h00 || op == 8'h40 || op == 8'h60)                      op_len = 2'd1;
    else if ((cc == 2'b00 || cc == 2'b10) && (bbb == 3'b010 || bbb == 3'b110)) op_len = 2'd1;
    else if (cc == 2'b11)                                               op_len = 2'd1;
    else if (op == 8'h20)                                               op_len = 2'd3;
    else if (bbb == 3'b011 || bbb == 3'b111 || (bbb == 3'b110 && cc == 2'b01)) op_len = 2'd3;
    else                                                                op_len = 2'd2;
  endfunction

  logic [DATA_WIDTH-1:0] q_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_d [QUEUE_DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [OW-1:0]         out_q, out_d, drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;

  logic [DATA_WIDTH-1:0] b0, b1, b2;
  logic [SW-1:0]         credit_used;
  logic                  req_raw, grant, rsp, push, pop, valid_w;
  logic [1:0]            len_w;

  assign b0 = q_q[head_q];
  assign b1 = q_q[head_q + PW'(1)];
  assign b2 = q_q[head_q + PW'(2)];

  // Credit check on registered state only: every granted read already owns a
  // queue slot, so a response can never find the queue full.
  assign credit_used = SW'(count_q) + SW'(out_q);
  assign req_raw = reset_n && (credit_used < SW'(QUEUE_DEPTH)) &&
                   (out_q < OW'(MAX_OUTSTANDING));
  // A grant against the pending request is honoured even in a redirect cycle
  // (mem_req is already low then); its byte is later dropped as stale.
  assign grant   = req_raw && mem_gnt;
  // Responses with nothing outstanding are stragglers from before a reset.
  assign rsp     = reset_n && mem_rvalid && (out_q != '0);
  assign push    = rsp && (drop_q == '0) && !redirect_valid;
  assign len_w   = op_len(b0[7:0]);
  assign valid_w = reset_n && !redirect_valid && (count_q >= CW'(len_w));
  assign pop     = valid_w && instr_ready;

  assign mem_req      = req_raw && !redirect_valid;
  assign mem_addr     = fetch_pc_q;
  assign instr_valid  = valid_w;
  assign instr_len    = valid_w ? len_w : 2'd0;
  assign instr_opcode = valid_w ? b0 : '0;
  assign instr_op1    = (valid_w && len_w >= 2'd2) ? b1 : '0;
  assign instr_op2    = (valid_w && len_w == 2'd3) ? b2 : '0;
  assign instr_pc     = head_pc_q;
  assign pc_next      = head_pc_q + ADDR_WIDTH'(instr_len);

  always_comb begin
    q_d        = q_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    out_d      = out_q + OW'(grant) - OW'(rsp);
    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      head_pc_d  = redirect_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = out_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 1'b1;
      if (rsp && drop_q != '0) drop_d = drop_q - 1'b1;
      if (push) begin
        q_d[tail_q] = mem_rdata;
        tail_d      = tail_q + 1'b1;
      end
      if (pop) begin
        head_d    = head_q + PW'(len_w);
        head_pc_d = head_pc_q + ADDR_WIDTH'(len_w);
      end
      count_d = count_q + CW'(push) - (pop ? CW'(len_w) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
    end else begin
      q_q        <= q_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count_q == CW'(QUEUE_DEPTH)));

endmodule
